// File: rtl/mux_n_pipe.sv
// N-input registered multiplexer with valid/ready handshake and a 2-entry skid buffer.
// Optional select range checking is enabled by defining MUX_N_PIPE_SEL_CHECK_EN.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [N*WIDTH-1:0] in_args,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;

  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] pick_data;
  logic [SEL_W-1:0] pick_sel;
  logic             pick_hit;

  // Ready depends only on the skid register, so it never combinationally follows out_ready.
  assign in_ready = !skid_valid_q && !RST;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    pick_hit  = 1'b0;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    pick_data = '0;
    pick_sel  = in_sel;
`else
    pick_data = in_args[WIDTH-1:0];
    pick_sel  = '0;
`endif
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        pick_data = in_args[k*WIDTH +: WIDTH];
        pick_sel  = in_sel;
        pick_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sel_d    = skid_sel_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = pick_data;
        out_sel_d   = pick_sel;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = pick_data;
      skid_sel_d   = pick_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    skid_data_q <= skid_data_d;
    skid_sel_q  <= skid_sel_d;
  end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q || (accept && !pick_hit);

  always_ff @(posedge CLK) begin
    if (RST) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  logic unused_hit;
  assign unused_hit = pick_hit;
  assign sel_err    = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: an N=4 instance under directed and random traffic,
// plus an N=3 instance exercising out-of-range selects.
module tb_mux_n_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [1:0]  in_sel, out_sel;
  logic [31:0] out_data;
  logic [31:0] arg [4];
  logic [127:0] in_args;

  logic        v3, rdy3, ov3, or3, se3;
  logic [1:0]  s3, os3;
  logic [23:0] a3;
  logic [7:0]  od3;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_data [$];
  logic [1:0]  q_sel [$];
  logic        stall_prev;
  logic [31:0] prev_data;
  logic [1:0]  prev_sel;

  always #5 CLK = ~CLK;

  assign in_args = {arg[3], arg[2], arg[1], arg[0]};

  mux_n_pipe #(.WIDTH(32), .N(4)) u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_args(in_args), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .sel_err(sel_err));

  mux_n_pipe #(.WIDTH(8), .N(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .in_valid(v3), .in_ready(rdy3),
    .in_sel(s3), .in_args(a3), .out_valid(ov3),
    .out_ready(or3), .out_data(od3), .out_sel(os3),
    .sel_err(se3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: inputs and registers are stable at the falling edge, so what is seen
  // here is exactly what the next rising edge will act on.
  always @(negedge CLK) begin
    if (RST) begin
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      q_data.delete();
      q_sel.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(q_data.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q_data.size() > 0));
      chk("sel_err_n4", 64'(sel_err), 64'd0);
      if (stall_prev && out_valid) begin
        chk("stall_data_stable", 64'(out_data), 64'(prev_data));
        chk("stall_sel_stable", 64'(out_sel), 64'(prev_sel));
      end
      if (out_valid && out_ready && q_data.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q_data.pop_front()));
        chk("out_sel", 64'(out_sel), 64'(q_sel.pop_front()));
      end
      if (in_valid && in_ready) begin
        q_data.push_back(arg[in_sel]);
        q_sel.push_back(in_sel);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sel   = out_sel;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    stall_prev = 1'b0;
    RST = 1'b1; in_valid = 1'b1; in_sel = 2'd1; out_ready = 1'b0;
    arg[0] = 32'h11; arg[1] = 32'h22; arg[2] = 32'h33; arg[3] = 32'h44;
    v3 = 1'b1; s3 = 2'd0; a3 = {8'h55, 8'h66, 8'hAA}; or3 = 1'b1;

    // Reset held two cycles with in_valid asserted
    repeat (2) step();
    RST = 1'b0; in_valid = 1'b0; v3 = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sel_err3", 64'(se3), 64'd0);
    chk("rst_in_ready3", 64'(rdy3), 64'd1);

    // Out-of-range select on the N=3 instance
    step();
    v3 = 1'b1; s3 = 2'd3;
    step();
    s3 = 2'd1;
    @(negedge CLK);
    chk("oor_out_valid", 64'(ov3), 64'd1);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    chk("oor_sel_err", 64'(se3), 64'd1);
    chk("oor_out_data", 64'(od3), 64'h00);
    chk("oor_out_sel", 64'(os3), 64'd3);
`else
    chk("oor_sel_err", 64'(se3), 64'd0);
    chk("oor_out_data", 64'(od3), 64'hAA);
    chk("oor_out_sel", 64'(os3), 64'd0);
`endif
    step();
    v3 = 1'b0;
    @(negedge CLK);
    chk("inrange_out_data", 64'(od3), 64'h66);
    chk("inrange_out_sel", 64'(os3), 64'd1);
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    chk("sel_err_sticky", 64'(se3), 64'd1);
`else
    chk("sel_err_sticky", 64'(se3), 64'd0);
`endif

    // Streaming at full rate: sels 3,0,2,1
    out_ready = 1'b1;
    step();
    foreach (q_sel[i]) ;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel = (i == 0) ? 2'd3 : (i == 1) ? 2'd0 : (i == 2) ? 2'd2 : 2'd1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Backpressure: sel 1 to output, sel 2 to skid, sel 3 must wait
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    step();
    in_sel = 2'd2;
    step();
    in_sel = 2'd3;
    @(negedge CLK);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step();
    out_ready = 1'b1;
    waited = 0;
    @(negedge CLK);
    while (!in_ready && waited < 10) begin
      waited++;
      @(negedge CLK);
    end
    chk("bp_recovery_in_time", 64'(waited < 10), 64'd1);
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Mid-flight reset with output and skid both full
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    step();
    in_sel = 2'd3;
    step();
    in_valid = 1'b0;
    @(negedge CLK);
    chk("mid_full_out_valid", 64'(out_valid), 64'd1);
    chk("mid_full_in_ready", 64'(in_ready), 64'd0);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) step();

    // Random soak
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) arg[k] = $urandom;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    @(negedge CLK);
    chk("soak_drained", 64'(q_data.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake and a 2-entry skid buffer, for pipeline-stage operand and writeback selection. It selects one of N flattened input words per accepted transfer and presents the selected word with its select index one cycle later. Input ready depends only on registered state, which breaks the ready path between adjacent pipeline stages.

## Interface
- `WIDTH`, 32, data width in bits (1–64)
- `N`, 4, number of inputs (2–16; non-power-of-two allowed)
- `SEL_W`, `$clog2(N)`, select width (derived; do not override)
- `CLK` in 1, rising-edge clock
- `RST` in 1, reset; synchronous, active-high; single clock domain
- `in_valid` in 1, upstream transfer valid
- `in_ready` out 1, block can accept a transfer
- `in_sel` in SEL_W, input index; sampled on accept
- `in_args` in N*WIDTH, flattened inputs; Arg k = `in_args[k*WIDTH +: WIDTH]`
- `out_valid` out 1, output word valid
- `out_ready` in 1, downstream accepts
- `out_data` out WIDTH, selected word
- `out_sel` out SEL_W, index that produced `out_data`
- `sel_err` out 1, sticky out-of-range select flag (see Configuration)

## Operation
- Storage: an output register (`out_data`, `out_sel`, `out_valid`) and a skid register (`skid_data`, `skid_sel`, `skid_valid`).
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- `in_ready = !skid_valid && !RST`. It is a function of registered state only.
- On accept, the selected word Arg[`in_sel`] is captured together with `in_sel`. `in_args` is not stored.
- Routing on each clock edge:
  - Output empty, or draining, with skid empty: an accepted word loads the output register.
  - Output full and not draining: an accepted word loads the skid register.
  - Draining with skid full: skid moves to the output register and skid clears. No accept is possible that cycle because `in_ready` = 0.
  - Draining with no accept and skid empty: `out_valid` falls to 0.
- Ordering is strict FIFO and never more than 2 words are in flight. No word is dropped or duplicated.
- `out_data` and `out_sel` hold stable while `out_valid && !out_ready`.
- Out-of-range select (`in_sel >= N`, possible only when N is not a power of two): the word is Arg0 and `out_sel` = 0, unless the feature is enabled.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `skid_valid` = 0, `sel_err` = 0. `in_ready` = 0 while `RST` = 1 and 1 in the first cycle after `RST` falls.
- Reset asserted mid-operation discards both held words at the next edge. Accept and drain in a cycle with `RST` = 1 are ignored.
- Latency: a word accepted at edge t is presented with `out_valid` = 1 after edge t, in cycle t+1.
- Throughput: 1 word/cycle with `out_ready` held high, and `in_ready` stays 1.
- Backpressure: when `out_ready` falls, exactly one more word is accepted into skid, then `in_ready` falls in the next cycle.
- Recovery: `in_ready` rises in the cycle after the skid empties.
- Simultaneous accept and drain with output full and skid empty: the new word replaces the output word and `skid_valid` stays 0.

## Configuration
- Macro `MUX_N_PIPE_SEL_CHECK_EN`.
- Defined:
  - An accept with `in_sel >= N` sets `sel_err` = 1 at that edge, and it holds until `RST`.
  - The offending word propagates as data 0 with `out_sel` = `in_sel` as given.
- Undefined:
  - `sel_err` is tied to 0.
  - Out-of-range selects return Arg0 with `out_sel` = 0.
  - No check logic is synthesised.

## Test plan
- Reset: hold `RST` 2 cycles with `in_valid` = 1.
  - During reset: `in_ready` = 0.
  - After release: `out_valid` = 0, `out_data` = 0, and `in_ready` = 1 the cycle after release.
- Streaming (N=4, WIDTH=32): Args = 0x11, 0x22, 0x33, 0x44; `out_ready` = 1; sels 3,0,2,1 on consecutive cycles.
  - Outputs one cycle later: 0x44, 0x11, 0x33, 0x22 with matching `out_sel`.
  - `in_ready` never drops.
- Backpressure: `out_ready` = 0 while sending sels 1, 2, 3.
  - Sel 1 goes to output, sel 2 goes to skid, and `in_ready` = 0 before sel 3.
  - Raising `out_ready` yields 0x22 then 0x33, and sel 3 is accepted once `in_ready` returns.
- Mid-flight reset: with output and skid both full, pulse `RST` for 1 cycle.
  - Next cycle: `out_valid` = 0 and skid is empty.
  - The previously held words never appear.
- Out-of-range (N=3, `in_sel` = 3, Arg0 = 0xAA):
  - With macro: `sel_err` = 1 (sticky), `out_data` = 0, `out_sel` = 3.
  - Without macro: `sel_err` = 0, `out_data` = 0xAA, `out_sel` = 0.
- Random soak: 10k cycles of random `in_valid`, `out_ready` and `in_sel`.
  - A scoreboard confirms in-order, loss-free delivery.
  - `out_data` is stable under stall.
